// File: rtl/mmu_fill_ctrl.sv
// Background filler for the MMU RAM. It writes ENTRIES page entries for one task key,
// using only the cycles where the CPU side leaves the shared RAM port idle.
module mmu_fill_ctrl #(
  parameter int ENTRIES   = 8,
  parameter int STEP      = 1,
  parameter int WR_CYCLES = 2
) (
  input  logic       CLKX4,
  input  logic       RESET,
  input  logic       CPU_REQ,
  input  logic       START,
  input  logic       ABORT,
  input  logic [4:0] TASK,
  input  logic [7:0] BASE,
  output logic       GNT,
  output logic [7:0] MMU_ADDR,
  output logic [7:0] MMU_DATA,
  output logic       MMU_DATA_oe,
  output logic       MMU_nWR,
  output logic       BUSY,
  output logic       DONE,
  output logic       ABORTED
);

  localparam int         CW         = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [2:0] ENTRY_LAST = 3'(ENTRIES - 1);
  localparam logic [CW-1:0] WCNT_LAST = CW'(WR_CYCLES - 1);
  localparam logic [7:0] STEP8      = 8'(STEP);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETUP, S_WRITE, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [4:0]    task_q, task_d;
  logic [2:0]    entry_q, entry_d;
  logic [7:0]    data_q, data_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          gnt_q, gnt_d;
  logic          oe_q, oe_d;
  logic          nwr_q, nwr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLKX4 or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      task_q    <= '0;
      entry_q   <= '0;
      data_q    <= '0;
      wcnt_q    <= '0;
      gnt_q     <= 1'b0;
      oe_q      <= 1'b0;
      nwr_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      task_q    <= task_d;
      entry_q   <= entry_d;
      data_q    <= data_d;
      wcnt_q    <= wcnt_d;
      gnt_q     <= gnt_d;
      oe_q      <= oe_d;
      nwr_q     <= nwr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    task_d    = task_q;
    entry_d   = entry_q;
    data_d    = data_q;
    wcnt_d    = wcnt_q;
    gnt_d     = gnt_q;
    oe_d      = oe_q;
    nwr_d     = nwr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          task_d  = TASK;
          data_d  = BASE;
          entry_d = '0;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ABORT) begin
          aborted_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (!CPU_REQ) begin
          gnt_d   = 1'b1;
          oe_d    = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        // Backing off here costs nothing: nWR has not fallen yet, so the entry is simply retried.
        if (CPU_REQ) begin
          gnt_d   = 1'b0;
          oe_d    = 1'b0;
          state_d = S_WAIT;
        end else begin
          nwr_d   = 1'b0;
          wcnt_d  = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wcnt_q == WCNT_LAST) begin
          nwr_d   = 1'b1;
          state_d = S_HOLD;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        gnt_d = 1'b0;
        oe_d  = 1'b0;
        // Completion outranks a late abort so a fully written map reports DONE.
        if (entry_q == ENTRY_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (ABORT) begin
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          entry_d = entry_q + 1'b1;
          data_d  = data_q + STEP8;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign GNT         = gnt_q;
  assign MMU_ADDR    = {task_q, entry_q};
  assign MMU_DATA    = data_q;
  assign MMU_DATA_oe = oe_q;
  assign MMU_nWR     = nwr_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ABORTED     = aborted_q;

endmodule

// File: tb/tb_mmu_fill_ctrl.sv
// Self-checking bench for mmu_fill_ctrl: directed fills plus randomized CPU contention,
// with writes compared against the arithmetic page map {task,i} -> BASE + i*STEP.
module tb_mmu_fill_ctrl;

  localparam int ENTRIES = 8;
  localparam int STEP    = 1;
  localparam int WR      = 2;

  logic       CLKX4 = 1'b0;
  logic       RESET = 1'b1;
  logic       CPU_REQ = 1'b0;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [4:0] TASK = '0;
  logic [7:0] BASE = '0;
  logic       GNT, MMU_DATA_oe, MMU_nWR, BUSY, DONE, ABORTED;
  logic [7:0] MMU_ADDR, MMU_DATA;

  mmu_fill_ctrl #(.ENTRIES(ENTRIES), .STEP(STEP), .WR_CYCLES(WR)) dut (
    .CLKX4(CLKX4), .RESET(RESET), .CPU_REQ(CPU_REQ), .START(START), .ABORT(ABORT),
    .TASK(TASK), .BASE(BASE), .GNT(GNT), .MMU_ADDR(MMU_ADDR), .MMU_DATA(MMU_DATA),
    .MMU_DATA_oe(MMU_DATA_oe), .MMU_nWR(MMU_nWR), .BUSY(BUSY), .DONE(DONE), .ABORTED(ABORTED)
  );

  always #5 CLKX4 = ~CLKX4;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int          cyc = 0;
  logic        req_at_edge = 1'b0;
  logic [15:0] writes[$];
  int          done_cnt = 0, aborted_cnt = 0, done_edge = 0;
  bit          gnt_rise = 0;
  bit          gnt_prev = 0, nwr_prev = 1, done_prev = 0, in_pulse = 0;
  int          plen = 0;
  logic [7:0]  paddr, pdata;

  always @(posedge CLKX4) begin
    cyc         <= cyc + 1;
    req_at_edge <= CPU_REQ;
  end

  always @(negedge CLKX4) begin
    gnt_rise = 0;
    if (RESET) begin
      in_pulse  = 0;
      gnt_prev  = 0;
      nwr_prev  = 1;
      done_prev = 0;
    end else begin
      if (GNT && !gnt_prev) begin
        gnt_rise = 1;
        check("gnt_rise_after_req", 32'(req_at_edge), 0);
      end
      if (GNT || MMU_DATA_oe) check("oe_eq_gnt", 32'(MMU_DATA_oe), 32'(GNT));
      if (GNT) check("gnt_implies_busy", 32'(BUSY), 1);
      if (!MMU_nWR) begin
        if (nwr_prev) begin
          in_pulse = 1;
          plen     = 1;
          paddr    = MMU_ADDR;
          pdata    = MMU_DATA;
          check("nwr_needs_gnt", 32'(GNT), 1);
        end else begin
          plen++;
          check("wr_stable", 32'({MMU_ADDR, MMU_DATA}), 32'({paddr, pdata}));
        end
      end else if (!nwr_prev && in_pulse) begin
        check("nwr_len", 32'(plen), 32'(WR));
        writes.push_back({paddr, pdata});
        in_pulse = 0;
      end
      if (DONE) begin
        done_cnt++;
        done_edge = cyc;
        check("done_one_clock", 32'(done_prev), 0);
      end
      if (ABORTED) aborted_cnt++;
      if (DONE || ABORTED) check("done_xor_aborted", 32'(DONE && ABORTED), 0);
      gnt_prev  = GNT;
      nwr_prev  = MMU_nWR;
      done_prev = DONE;
    end
  end

  // ---------------- driver helpers ----------------
  int wbase, dbase, abase, start_edge;

  task automatic tick();
    @(negedge CLKX4);
    #1;
  endtask

  task automatic mark();
    wbase = writes.size();
    dbase = done_cnt;
    abase = aborted_cnt;
  endtask

  task automatic start_fill(input logic [4:0] t, input logic [7:0] b);
    mark();
    TASK       = t;
    BASE       = b;
    START      = 1'b1;
    start_edge = cyc + 1;
    tick();
    START = 1'b0;
  endtask

  // Waits for DONE or ABORTED; a blown budget is reported as a failed comparison.
  task automatic wait_end();
    int n = 0;
    while (done_cnt == dbase && aborted_cnt == abase && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) check("end_timeout", 0, 1);
  endtask

  task automatic check_writes(input logic [4:0] t, input logic [7:0] b, input int n_exp);
    int n = writes.size() - wbase;
    check("write_count", 32'(n), 32'(n_exp));
    for (int i = 0; i < n && i < n_exp; i++) begin
      logic [7:0] ea = {t, 3'(i)};
      logic [7:0] ed = 8'(int'(b) + i * STEP);
      check("entry_addr", 32'(writes[wbase+i][15:8]), 32'(ea));
      check("entry_data", 32'(writes[wbase+i][7:0]), 32'(ed));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) tick();
    check("rst_gnt", 32'(GNT), 0);
    check("rst_oe", 32'(MMU_DATA_oe), 0);
    check("rst_nwr", 32'(MMU_nWR), 1);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done_abort", 32'({DONE, ABORTED}), 0);
    check("rst_addr_data", 32'({MMU_ADDR, MMU_DATA}), 0);
    RESET = 1'b0;
    tick();

    // Basic uncontended fill and its timing
    start_fill(5'd5, 8'h10);
    check("busy_after_start", 32'(BUSY), 1);
    wait_end();
    check("basic_done", 32'(done_cnt - dbase), 1);
    check("basic_latency", 32'(done_edge - start_edge), 32'(ENTRIES * (WR + 3)));
    check_writes(5'd5, 8'h10, ENTRIES);
    tick();
    check("basic_busy_low", 32'(BUSY), 0);

    // Data wrap
    start_fill(5'd31, 8'hFE);
    wait_end();
    check_writes(5'd31, 8'hFE, ENTRIES);

    // Contention in entry 3's SETUP
    start_fill(5'd12, 8'h80);
    begin
      int n = 0;
      while (!(gnt_rise && MMU_ADDR[2:0] == 3'd3) && n < 500) begin tick(); n++; end
      check("reach_setup3", 32'(n < 500), 1);
    end
    CPU_REQ = 1'b1;
    tick();
    check("setup_backoff_gnt", 32'(GNT), 0);
    check("setup_backoff_nwr", 32'(MMU_nWR), 1);
    repeat (3) tick();
    check("wait_while_req", 32'(GNT), 0);
    CPU_REQ = 1'b0;
    wait_end();
    check("contend_done", 32'(done_cnt - dbase), 1);
    check_writes(5'd12, 8'h80, ENTRIES);

    // CPU request arriving during WRITE
    start_fill(5'd7, 8'h33);
    begin
      int n = 0;
      while (!(!MMU_nWR && MMU_ADDR[2:0] == 3'd2) && n < 500) begin tick(); n++; end
      check("reach_write2", 32'(n < 500), 1);
    end
    CPU_REQ = 1'b1;
    repeat (4) tick();
    check("req_in_write_wait", 32'(GNT), 0);
    check("req_in_write_busy", 32'(BUSY), 1);
    CPU_REQ = 1'b0;
    wait_end();
    check_writes(5'd7, 8'h33, ENTRIES);

    // Abort during entry 4's WRITE, plus a START that must be ignored
    start_fill(5'd9, 8'h40);
    begin
      int n = 0;
      while (!(!MMU_nWR && MMU_ADDR[2:0] == 3'd4) && n < 500) begin tick(); n++; end
      check("reach_write4", 32'(n < 500), 1);
    end
    ABORT = 1'b1;
    TASK  = 5'd3;
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_end();
    ABORT = 1'b0;
    check("abort_pulse", 32'(aborted_cnt - abase), 1);
    check("abort_no_done", 32'(done_cnt - dbase), 0);
    check("abort_busy", 32'(BUSY), 0);
    check_writes(5'd9, 8'h40, 5);

    // START and ABORT together in IDLE: START wins, abort taken in WAIT
    tick();
    mark();
    TASK  = 5'd2;
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    check("start_wins", 32'(BUSY), 1);
    wait_end();
    ABORT = 1'b0;
    check("wait_abort", 32'(aborted_cnt - abase), 1);
    check_writes(5'd2, 8'h00, 0);

    // Reset in WRITE
    tick();
    start_fill(5'd20, 8'h55);
    begin
      int n = 0;
      while (MMU_nWR && n < 500) begin tick(); n++; end
      check("reach_write_rst", 32'(n < 500), 1);
    end
    #2 RESET = 1'b1;
    #1;
    check("rst_mid_nwr", 32'(MMU_nWR), 1);
    check("rst_mid_gnt", 32'(GNT), 0);
    check("rst_mid_oe", 32'(MMU_DATA_oe), 0);
    check("rst_mid_busy", 32'(BUSY), 0);
    tick();
    RESET = 1'b0;
    repeat (60) tick();
    check("rst_no_done", 32'(done_cnt - dbase), 0);
    check("rst_idle_busy", 32'(BUSY), 0);

    // Randomized contention and aborts
    for (int it = 0; it < 12; it++) begin
      logic [4:0] t = 5'($urandom);
      logic [7:0] b = 8'($urandom);
      int abort_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : -1;
      int n = 0, nw;
      start_fill(t, b);
      while (done_cnt == dbase && aborted_cnt == abase && n < 3000) begin
        CPU_REQ = ($urandom_range(0, 2) == 0);
        ABORT   = (abort_at >= 0 && n >= abort_at);
        tick();
        n++;
      end
      if (n >= 3000) check("rand_timeout", 0, 1);
      CPU_REQ = 1'b0;
      ABORT   = 1'b0;
      nw = writes.size() - wbase;
      if (done_cnt != dbase) begin
        check_writes(t, b, ENTRIES);
      end else begin
        check("rand_abort_short", 32'(nw < ENTRIES), 1);
        check_writes(t, b, nw);
      end
      tick();
      check("rand_busy_low", 32'(BUSY), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmu_fill_ctrl.md
Name: mmu_fill_ctrl

Overview:
- Background sequencer that bulk-loads one task's page map into the external MMU RAM. It writes page entries 0..ENTRIES-1 for a selected task key.
- Shares the MMU RAM port with the CPU-side translation/access logic. The CPU side always has priority; the filler steals idle cycles only.
- Sits beside the MMU/interrupt CPLD logic. An external mux uses GNT to select filler-driven MMU_ADDR/MMU_DATA/MMU_nWR over the CPU-side drivers.

Parameters:
- ENTRIES, 8: page entries per task; power of two, max 8.
- STEP, 1: value added to the page value for each successive entry (8-bit, wraps).
- WR_CYCLES, 2: width of the MMU_nWR low pulse in clocks; must be at least 1.

Ports:
- CLKX4  in  1  system clock, all state on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CPU_REQ  in  1  CPU side needs MMU RAM this cycle (translation or register access).
- START  in  1  one-clock pulse that starts a fill.
- ABORT  in  1  stops the fill at the next safe point.
- TASK  in  5  task key to fill; captured on START.
- BASE  in  8  page value for entry 0; captured on START.
- GNT  out  1  filler owns MMU RAM address, data and nWR.
- MMU_ADDR  out  8  {task[4:0], entry[2:0]}.
- MMU_DATA  out  8  entry value = BASE + entry*STEP (mod 256).
- MMU_DATA_oe  out  1  filler drives MMU data bus.
- MMU_nWR  out  1  active-low write strobe.
- BUSY  out  1  fill in progress.
- DONE  out  1  one-clock pulse when all entries are written.
- ABORTED  out  1  one-clock pulse when a fill ends early.

Behaviour:
- Reset (async):
  - State IDLE, GNT=0, MMU_DATA_oe=0, MMU_nWR=1, BUSY=0, DONE=0, ABORTED=0.
  - MMU_ADDR=0, MMU_DATA=0, entry counter=0.
  - Reset mid-write releases nWR immediately. The partially written entry is undefined.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, WAIT, SETUP, WRITE, HOLD.
- IDLE:
  - START=1 latches TASK/BASE, clears the entry counter, sets BUSY=1 and goes to WAIT.
  - START while BUSY=1 is ignored.
- WAIT:
  - GNT=0.
  - If ABORT=1: go to IDLE, pulse ABORTED, BUSY=0.
  - Else if CPU_REQ=0: go to SETUP with GNT=1, MMU_DATA_oe=1, address and data valid, nWR=1.
- SETUP (1 clock):
  - If CPU_REQ=1: drop GNT and MMU_DATA_oe, return to WAIT. Nothing is written; the entry is retried.
  - Else go to WRITE with nWR=0.
- WRITE:
  - nWR=0 for exactly WR_CYCLES clocks.
  - CPU_REQ and ABORT are ignored, so an entry is never torn.
  - CPU worst-case wait is WR_CYCLES+1 clocks.
- HOLD (1 clock):
  - nWR=1; GNT, address and data are held for data hold time.
  - Then either:
    - Last entry (counter=ENTRIES-1): go to IDLE, GNT=0, BUSY=0, pulse DONE.
    - ABORT=1: go to IDLE, pulse ABORTED.
    - Otherwise: increment the counter, add STEP to the data, go to WAIT.
- GNT rules:
  - GNT=1 only in SETUP, WRITE and HOLD.
  - GNT never rises in a cycle where CPU_REQ was sampled high.
- Timing:
  - Uncontended fill takes ENTRIES*(WR_CYCLES+3) clocks from START to DONE. With defaults: 8*5=40 clocks.
- Arithmetic:
  - Data is 8-bit modular: BASE=0xFE, STEP=1 gives FE, FF, 00, 01, …
  - The entry counter is 3 bits, with MMU_ADDR[2:0]=counter. When ENTRIES<8, the upper counter bits stay 0.
- Simultaneous events:
  - START and ABORT together in IDLE: START wins; ABORT is acted on in WAIT next cycle.
  - DONE and ABORTED are never both asserted.
  - ABORT in HOLD of the last entry gives DONE, not ABORTED.

Test Plan:
- Basic fill: RESET, START with TASK=5, BASE=0x10, CPU_REQ=0.
  - 8 writes with MMU_ADDR=0x28..0x2F and data 0x10..0x17.
  - Each nWR low for exactly 2 clocks.
  - DONE 40 clocks after START, BUSY low after.
- Wrap: TASK=31, BASE=0xFE, STEP=1.
  - Data FE, FF, 00..05; addresses F8..FF.
- Contention: hold CPU_REQ=1 in the same cycle as entry 3's SETUP.
  - GNT drops next clock with no nWR pulse.
  - Entry 3 is rewritten after CPU_REQ falls.
  - Total writes still 8; GNT never high while CPU_REQ was high the prior clock.
- CPU_REQ during WRITE: the write completes (2-clock nWR), then GNT=0 in WAIT until CPU_REQ=0.
- Abort and ignored start:
  - ABORT during entry 4's WRITE: entry 4 completes, ABORTED pulses after HOLD, BUSY=0, 5 writes total.
  - START while BUSY is ignored (TASK unchanged).
- Reset in WRITE: nWR, GNT and MMU_DATA_oe go inactive asynchronously, state IDLE, no DONE.
